prim_clock_div_prog: RTL and testbench

Programmable, glitch-free integer clock divider with clean start/stop, boundary-synchronous ratio changes and a scan bypass. It sits in the clock-generation layer next to the generic clock primitives and derives slow peripheral clocks from a fast root clock. In scan mode the divided clock is replaced by the root clock so test clocking stays controllable. The divided output always comes from a register: no combinational path from counter state to `clk_o` in functional mode.

---
 rtl/prim_clock_div_prog.sv | 124 ++++++++++++
 tb/tb_prim_clock_div_prog.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : prim_clock_div_prog
// Brief    : Programmable glitch-free integer clock divider with registered
//            output, period-boundary ratio changes and a scan bypass.
// Revision : 1.0 - initial release
// ============================================================================

module prim_clock_div_prog #(
   parameter int unsigned Width       = 8,
   parameter int unsigned ResetDiv    = 2,
   parameter bit          HasScanMode = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             scanmode_i,
   input  logic             en_i,
   input  logic [Width-1:0] div_i,
   input  logic             div_req_i,
   output logic             div_pend_o,
   output logic             div_ack_o,
   output logic             active_o,
   output logic             clk_o
);

   localparam logic [Width-1:0] c_one       = Width'(1);
   localparam logic [Width-1:0] c_two       = Width'(2);
   localparam logic [Width-1:0] c_reset_div = Width'(ResetDiv);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e           r_state;
   logic [Width-1:0] r_cnt;
   logic [Width-1:0] r_div;
   logic [Width-1:0] r_pend_div;
   logic             r_pend;
   logic             r_ack;
   logic             r_clk;

   logic [Width-1:0] w_div_clamped;
   logic [Width-1:0] w_half;
   logic [Width-1:0] w_cnt_inc;
   logic             w_wrap;
   logic             w_apply;

   assign w_div_clamped = (div_i < c_two) ? c_two : div_i;
   assign w_half        = r_div >> 1;
   assign w_cnt_inc     = r_cnt + c_one;
   assign w_wrap        = (r_state == ST_RUN) && (r_cnt == (r_div - c_one));
   // A pending ratio lands either at a period boundary or straight away when idle.
   assign w_apply       = r_pend && ((r_state == ST_IDLE) || w_wrap);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_div      <= c_reset_div;
         r_pend_div <= c_reset_div;
         r_pend     <= 1'b0;
         r_ack      <= 1'b0;
         r_clk      <= 1'b0;
      end else begin
         r_ack <= w_apply;
         if (w_apply) begin
            r_div  <= r_pend_div;
            r_pend <= 1'b0;
         end else if (div_req_i && !r_pend) begin
            r_pend     <= 1'b1;
            r_pend_div <= w_div_clamped;
         end

         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (en_i) begin
                  r_state <= ST_RUN;
                  r_clk   <= 1'b1;
               end else begin
                  r_clk   <= 1'b0;
               end
            end
            ST_RUN: begin
               if (w_wrap) begin
                  r_cnt <= '0;
                  if (en_i) begin
                     r_clk   <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_clk   <= 1'b0;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
                  r_clk <= (w_cnt_inc < w_half);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_clk   <= 1'b0;
            end
         endcase
      end
   end

   assign div_pend_o = r_pend;
   assign div_ack_o  = r_ack;
   assign active_o   = (r_state == ST_RUN);

   generate
      if (HasScanMode) begin : g_scan
         assign clk_o = scanmode_i ? clk_i : r_clk;
      end else begin : g_no_scan
         logic w_unused_scan;
         assign w_unused_scan = scanmode_i;
         assign clk_o         = r_clk;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_prim_clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_clock_div_prog
// Brief    : Scoreboard bench for prim_clock_div_prog against a waveform-queue
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_prim_clock_div_prog;

   logic       clk;
   logic       rst_n;
   logic       scanmode;
   logic       en;
   logic [7:0] div;
   logic       div_req;
   logic       div_pend;
   logic       div_ack;
   logic       active;
   logic       clk_out;

   prim_clock_div_prog #(
      .Width       (8),
      .ResetDiv    (2),
      .HasScanMode (1'b1)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .scanmode_i (scanmode),
      .en_i       (en),
      .div_i      (div),
      .div_req_i  (div_req),
      .div_pend_o (div_pend),
      .div_ack_o  (div_ack),
      .active_o   (active),
      .clk_o      (clk_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic clk;
      logic act;
      logic pend;
      logic ack;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   // Reference model: the remaining output samples of the current period.
   bit   m_wave[$];
   bit   m_active;
   int   m_div;
   int   m_pdiv;
   bit   m_pend;
   bit   m_ack;

   task automatic chk(input string nm, input logic act_v, input logic exp_v);
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act_v, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_wave.delete();
      m_active = 1'b0;
      m_div    = 2;
      m_pdiv   = 2;
      m_pend   = 1'b0;
      m_ack    = 1'b0;
   endtask

   task automatic start_period();
      for (int i = 0; i < m_div; i++) m_wave.push_back(i < m_div / 2);
   endtask

   task automatic model_step(input logic e, input logic r, input logic [7:0] d,
                             input logic s);
      bit   last;
      bit   apply;
      exp_t x;
      last  = m_active && (m_wave.size() == 1);
      apply = m_pend && (!m_active || last);
      m_ack = apply;
      if (apply) begin
         m_div  = m_pdiv;
         m_pend = 1'b0;
      end else if (r && !m_pend) begin
         m_pend = 1'b1;
         m_pdiv = (d < 2) ? 2 : int'(d);
      end
      if (m_active) begin
         void'(m_wave.pop_front());
         if (m_wave.size() == 0) begin
            if (e) start_period();
            else   m_active = 1'b0;
         end
      end else if (e) begin
         m_active = 1'b1;
         start_period();
      end
      x.clk  = s ? 1'b1 : (m_active ? m_wave[0] : 1'b0);
      x.act  = m_active;
      x.pend = m_pend;
      x.ack  = m_ack;
      exp_q.push_back(x);
   endtask

   task automatic cyc(input logic e, input logic r, input logic [7:0] d,
                      input logic s);
      @(negedge clk);
      en       = e;
      div_req  = r;
      div      = d;
      scanmode = s;
      model_step(e, r, d, s);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      mon_en   = 1'b0;
      en       = 1'b0;
      div_req  = 1'b0;
      scanmode = 1'b0;
      #1;
      chk("rst_clk_o", clk_out, 1'b0);
      chk("rst_active", active, 1'b0);
      chk("rst_pend", div_pend, 1'b0);
      chk("rst_ack", div_ack, 1'b0);
      exp_q.delete();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   // Monitor: one expected sample per clock cycle.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("clk_o", clk_out, e.clk);
            chk("active_o", active, e.act);
            chk("div_pend_o", div_pend, e.pend);
            chk("div_ack_o", div_ack, e.ack);
         end
      end
   end

   // In scan mode the output must also be low during the low half of clk_i.
   always @(negedge clk) begin
      #1;
      if (mon_en && scanmode) chk("scan_low", clk_out, 1'b0);
   end

   initial begin
      rst_n    = 1'b1;
      en       = 1'b0;
      div_req  = 1'b0;
      div      = 8'd0;
      scanmode = 1'b0;
      model_reset();
      #1;
      rst_n = 1'b0;
      #1;
      chk("init_clk_o", clk_out, 1'b0);
      chk("init_active", active, 1'b0);
      chk("init_pend", div_pend, 1'b0);
      chk("init_ack", div_ack, 1'b0);
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Default N = 2
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);

      // Switch to N = 5 with enable held
      cyc(1, 1, 8'd5, 0);
      for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);

      // Go to N = 8, then request 3 mid-period and a dropped 6 while pending
      cyc(1, 1, 8'd8, 0);
      for (int i = 0; i < 40 && !(m_div == 8 && m_wave.size() == 4); i++) cyc(1, 0, 0, 0);
      cyc(1, 1, 8'd3, 0);
      cyc(1, 1, 8'd6, 0);
      for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);

      // N = 4, then drop enable at cnt = 1
      cyc(1, 1, 8'd4, 0);
      for (int i = 0; i < 40 && !(m_div == 4 && m_wave.size() == 3); i++) cyc(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);

      // Ratio 0 and 1 from idle both clamp to 2
      cyc(0, 1, 8'd0, 0);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
      cyc(0, 1, 8'd9, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
      cyc(0, 1, 8'd1, 0);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

      // Scan bypass while running N = 4
      cyc(1, 1, 8'd4, 0);
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);

      // Async reset during a high phase with a ratio pending
      cyc(1, 1, 8'd7, 0);
      for (int i = 0; i < 20 && !(m_active && m_wave[0] && m_pend); i++) cyc(1, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         logic       e;
         logic       r;
         logic [7:0] d;
         logic       s;
         e = ($urandom % 8) != 0;
         r = ($urandom % 10) == 0;
         d = (($urandom % 4) == 0) ? 8'($urandom % 3) : 8'($urandom_range(2, 12));
         s = ($urandom % 20) == 0;
         cyc(e, r, d, s);
      end

      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
      @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
